// File: rtl/ccta_pkg.sv
// ccta_pkg: definitions shared by the CCTA datapath, its result collector,
// and the benches that exercise them.
//   DATA_W            : width of the CCTA result q.
//   collector_state_t : control states of ccta_result_collector.
package ccta_pkg;

    localparam int DATA_W = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } collector_state_t;

endpackage

// File: rtl/ccta_result_collector.sv
// ccta_result_collector: accepts CCTA results over a valid/ready handshake and
// accumulates frames of NUM_SAMPLES results into sum, max, min and count.
// The completed frame statistics are held in DONE until the next start.
//
// Ports:
//   clk      in   single clock, rising-edge
//   rst      in   synchronous active-high reset
//   start    in   begin a new frame (honoured in IDLE and DONE)
//   abort    in   cancel the frame in progress (honoured in COLLECT)
//   q_valid  in   upstream result valid
//   q        in   CCTA result
//   q_ready  out  collector can accept (high only in COLLECT)
//   sum      out  sum of accepted results
//   max_q    out  largest accepted result
//   min_q    out  smallest accepted result
//   cnt      out  number of results accepted in this frame
//   busy     out  high in COLLECT
//   done     out  high in DONE; statistics valid and stable
module ccta_result_collector
    import ccta_pkg::*;
#(
    parameter  int DATA_W      = ccta_pkg::DATA_W,
    parameter  int NUM_SAMPLES = 8,
    localparam int SUM_W       = DATA_W + $clog2(NUM_SAMPLES),
    localparam int CNT_W       = $clog2(NUM_SAMPLES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              q_valid,
    input  logic [DATA_W-1:0] q,
    output logic              q_ready,
    output logic [SUM_W-1:0]  sum,
    output logic [DATA_W-1:0] max_q,
    output logic [DATA_W-1:0] min_q,
    output logic [CNT_W-1:0]  cnt,
    output logic              busy,
    output logic              done
);

    localparam logic [DATA_W-1:0] MIN_INIT = '1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NUM_SAMPLES - 1);

    collector_state_t state;
    collector_state_t next_state;
    logic             clear;
    logic             accept;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        clear      = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    next_state = COLLECT;
                    clear      = 1'b1;
                end
            end
            COLLECT: begin
                // Abort beats a simultaneous transfer: that sample is dropped.
                if (abort) begin
                    next_state = IDLE;
                    clear      = 1'b1;
                end else if (q_valid) begin
                    accept = 1'b1;
                    if (cnt == LAST_CNT) begin
                        next_state = DONE;
                    end
                end
            end
            default: begin
                next_state = IDLE;
                clear      = 1'b1;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            q_ready <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            max_q   <= '0;
            min_q   <= MIN_INIT;
            cnt     <= '0;
        end else begin
            state   <= next_state;
            // Handshake/status flags are registered from next_state so they
            // depend on state only, never combinationally on q_valid.
            q_ready <= (next_state == COLLECT);
            busy    <= (next_state == COLLECT);
            done    <= (next_state == DONE);
            if (clear) begin
                sum   <= '0;
                max_q <= '0;
                min_q <= MIN_INIT;
                cnt   <= '0;
            end else if (accept) begin
                sum <= sum + SUM_W'(q);
                cnt <= cnt + CNT_W'(1);
                if (q > max_q) max_q <= q;
                if (q < min_q) min_q <= q;
            end
        end
    end

endmodule

// File: tb/tb_ccta_result_collector.sv
// tb_ccta_result_collector: drives two collectors (NUM_SAMPLES=4 and 8) with
// shared stimulus, compares both against a frame-level reference model on
// every cycle, and pins the model with hand-computed frame results.
module tb_ccta_result_collector;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       q_valid = 1'b0;
    logic [4:0] q = '0;

    // Instance A: NUM_SAMPLES=4 -> SUM_W=7, CNT_W=3
    logic       q_ready_a, busy_a, done_a;
    logic [6:0] sum_a;
    logic [4:0] max_a, min_a;
    logic [2:0] cnt_a;
    // Instance B: NUM_SAMPLES=8 -> SUM_W=8, CNT_W=4
    logic       q_ready_b, busy_b, done_b;
    logic [7:0] sum_b;
    logic [4:0] max_b, min_b;
    logic [3:0] cnt_b;

    ccta_result_collector #(.NUM_SAMPLES(4)) dut_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .q_valid(q_valid), .q(q), .q_ready(q_ready_a), .sum(sum_a),
        .max_q(max_a), .min_q(min_a), .cnt(cnt_a), .busy(busy_a), .done(done_a)
    );

    ccta_result_collector #(.NUM_SAMPLES(8)) dut_b (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .q_valid(q_valid), .q(q), .q_ready(q_ready_b), .sum(sum_b),
        .max_q(max_b), .min_q(min_b), .cnt(cnt_b), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d (0x%0h), expected %0d", name, act, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- reference model ----------------
    // Each frame is kept as the list of samples accepted so far; statistics
    // are derived from that list. phase: 0 idle, 1 collecting, 2 complete.
    int          phase [2];
    int          limit [2] = '{4, 8};
    int unsigned samples [2][64];
    int          n_samples [2];

    task automatic model_step(input int i);
        if (rst) begin
            phase[i] = 0;
            n_samples[i] = 0;
        end else if (phase[i] == 1) begin
            if (abort) begin
                phase[i] = 0;
                n_samples[i] = 0;
            end else if (q_valid) begin
                samples[i][n_samples[i]] = q;
                n_samples[i]++;
                if (n_samples[i] == limit[i]) phase[i] = 2;
            end
        end else if (start) begin
            phase[i] = 1;
            n_samples[i] = 0;
        end
    endtask

    function automatic int exp_sum(input int i);
        int s = 0;
        for (int k = 0; k < n_samples[i]; k++) s += samples[i][k];
        return s;
    endfunction

    function automatic int exp_max(input int i);
        int m = 0;
        for (int k = 0; k < n_samples[i]; k++) if (samples[i][k] > m) m = samples[i][k];
        return m;
    endfunction

    function automatic int exp_min(input int i);
        int m = 31;
        for (int k = 0; k < n_samples[i]; k++) if (samples[i][k] < m) m = samples[i][k];
        return m;
    endfunction

    initial begin
        for (int i = 0; i < 2; i++) begin
            phase[i] = 0;
            n_samples[i] = 0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) model_step(i);
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("a.sum",     32'(sum_a),     exp_sum(0));
            check("a.max_q",   32'(max_a),     exp_max(0));
            check("a.min_q",   32'(min_a),     exp_min(0));
            check("a.cnt",     32'(cnt_a),     n_samples[0]);
            check("a.q_ready", 32'(q_ready_a), 32'(phase[0] == 1));
            check("a.busy",    32'(busy_a),    32'(phase[0] == 1));
            check("a.done",    32'(done_a),    32'(phase[0] == 2));
            check("b.sum",     32'(sum_b),     exp_sum(1));
            check("b.max_q",   32'(max_b),     exp_max(1));
            check("b.min_q",   32'(min_b),     exp_min(1));
            check("b.cnt",     32'(cnt_b),     n_samples[1]);
            check("b.q_ready", 32'(q_ready_b), 32'(phase[1] == 1));
            check("b.busy",    32'(busy_b),    32'(phase[1] == 1));
            check("b.done",    32'(done_b),    32'(phase[1] == 2));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic r, input logic s, input logic a,
                         input logic v, input logic [4:0] d);
        @(negedge clk);
        rst = r; start = s; abort = a; q_valid = v; q = d;
    endtask

    task automatic idle_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic push(input logic [4:0] d);
        drive(1'b0, 1'b0, 1'b0, 1'b1, d);
    endtask

    task automatic begin_frame();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        idle_cycle();
        chk_en = 1'b1;
        check("reset.sum",   32'(sum_a),   32'd0);
        check("reset.min_q", 32'(min_a),   32'd31);
        check("reset.ready", 32'(q_ready_a), 32'd0);

        // Back-to-back frame 3, 17, 31, 0
        begin_frame();
        push(5'd3); push(5'd17); push(5'd31); push(5'd0);
        idle_cycle();
        check("b2b.sum",   32'(sum_a),   32'd51);
        check("b2b.max",   32'(max_a),   32'd31);
        check("b2b.min",   32'(min_a),   32'd0);
        check("b2b.cnt",   32'(cnt_a),   32'd4);
        check("b2b.done",  32'(done_a),  32'd1);
        check("b2b.ready", 32'(q_ready_a), 32'd0);

        // Gapped valid: 5,5,5,5 with 3 idle cycles between
        begin_frame();
        for (int k = 0; k < 4; k++) begin
            push(5'd5);
            repeat (3) idle_cycle();
        end
        check("gap.sum",  32'(sum_a),  32'd20);
        check("gap.max",  32'(max_a),  32'd5);
        check("gap.min",  32'(min_a),  32'd5);
        check("gap.done", 32'(done_a), 32'd1);

        // Abort colliding with a transfer
        begin_frame();
        push(5'd10); push(5'd12);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 5'd9);
        idle_cycle();
        check("abort.sum",  32'(sum_a),  32'd0);
        check("abort.min",  32'(min_a),  32'd31);
        check("abort.cnt",  32'(cnt_a),  32'd0);
        check("abort.busy", 32'(busy_a), 32'd0);

        // Reset mid-frame, then valid without start is ignored
        begin_frame();
        push(5'd7); push(5'd8); push(5'd9);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd4);
        push(5'd6);
        check("rst.sum",  32'(sum_a),  32'd0);
        check("rst.cnt",  32'(cnt_a),  32'd0);
        check("rst.min",  32'(min_a),  32'd31);
        push(5'd6);
        idle_cycle();
        check("rst.ignore.cnt",  32'(cnt_a),     32'd0);
        check("rst.ignore.busy", 32'(busy_a),    32'd0);

        // start mid-COLLECT ignored; then restart from DONE
        begin_frame();
        push(5'd3); push(5'd17);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd31);
        idle_cycle();
        check("midstart.cnt", 32'(cnt_a), 32'd3);
        push(5'd0);
        idle_cycle();
        check("restart.pre.sum",  32'(sum_a),  32'd51);
        check("restart.pre.done", 32'(done_a), 32'd1);
        begin_frame();
        idle_cycle();
        check("restart.sum",   32'(sum_a),     32'd0);
        check("restart.cnt",   32'(cnt_a),     32'd0);
        check("restart.done",  32'(done_a),    32'd0);
        check("restart.ready", 32'(q_ready_a), 32'd1);

        // Overflow bound on the 8-sample instance
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        begin_frame();
        repeat (8) push(5'd31);
        idle_cycle();
        check("ovf.sum",  32'(sum_b),  32'd248);
        check("ovf.max",  32'(max_b),  32'd31);
        check("ovf.min",  32'(min_b),  32'd31);
        check("ovf.done", 32'(done_b), 32'd1);
        check("ovf.cnt",  32'(cnt_b),  32'd8);

        // Randomized traffic, checked every cycle by the compare process
        for (int k = 0; k < 3000; k++) begin
            logic       r, s, a, v;
            logic [4:0] d;
            r = ($urandom_range(0, 199) == 0);
            s = ($urandom_range(0, 9) == 0);
            a = ($urandom_range(0, 24) == 0);
            v = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 5))
                0:       d = 5'd0;
                1:       d = 5'd31;
                default: d = 5'($urandom_range(0, 31));
            endcase
            drive(r, s, a, v, d);
        end
        idle_cycle();
        idle_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
